fp_normalize_round: RTL and testbench

//  Post-add stage of the IEEE-754 single-precision adder. Consumes the 28-bit magnitude
//  sum, sign and pre-add exponent from the mantissa adder, and normalises iteratively
//  (one bit per cycle). It then rounds to nearest-even and packs a 32-bit result.

---
 rtl/fp_normalize_round_pkg.sv | 33 +++
 rtl/fp_normalize_round_if.sv | 26 ++
 rtl/fp_normalize_round_rne.sv | 41 ++++
 rtl/fp_normalize_round.sv | 129 ++++++++++++
 tb/tb_fp_normalize_round.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fp_normalize_round_pkg.sv
// Shared constants, types and state encoding for the single-precision
// post-add normalise/round stage.
package fp_normalize_round_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MANT_W  = 23;
  localparam int unsigned SUM_W   = MANT_W + 5;
  localparam int unsigned EXPI_W  = EXP_W + 2;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  // Bit positions inside the adder sum: carry, hidden bit, fraction LSB, guard.
  localparam int unsigned CARRY_B = SUM_W - 1;
  localparam int unsigned HIDDEN_B = SUM_W - 2;
  localparam int unsigned LSB_B   = 3;
  localparam int unsigned GUARD_B = 2;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  typedef logic signed [EXPI_W-1:0] exp_int_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_normalize_round_if.sv
// Upstream/downstream handshake bundle for fp_normalize_round.
interface fp_normalize_round_if;
  import fp_normalize_round_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [SUM_W-1:0]  in_sum;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic              out_ovf;
  logic              out_zero;

  modport master (
    output in_valid, in_sign, in_exp, in_sum, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sum, out_ready,
    output in_ready, out_valid, out_result, out_ovf, out_zero
  );

endinterface

// File: rtl/fp_normalize_round_rne.sv
// Combinational round-to-nearest-even of a normalised (or denormal) sum
// and packing of the exponent/fraction fields with overflow detection.
module fp_normalize_round_rne
  import fp_normalize_round_pkg::*;
(
  input  logic [SUM_W-2:0]  i_sum,
  input  exp_int_t          i_exp,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MANT_W-1:0] o_frac,
  output logic              o_ovf
);

  logic            w_up;
  logic [MANT_W+1:0] w_m25;
  logic [MANT_W:0] w_m;
  exp_int_t        w_exp;

  assign w_up  = i_sum[GUARD_B] & (i_sum[1] | i_sum[0] | i_sum[LSB_B]);
  assign w_m25 = {1'b0, i_sum[HIDDEN_B:LSB_B]} + {{(MANT_W+1){1'b0}}, w_up};

  always_comb begin
    w_m    = w_m25[MANT_W:0];
    w_exp  = i_exp;
    o_exp  = '0;
    o_frac = '0;
    o_ovf  = 1'b0;
    if (w_m25[MANT_W+1]) begin
      w_m   = w_m25[MANT_W+1:1];
      w_exp = i_exp + exp_int_t'(1);
    end
    if (w_exp >= exp_int_t'(EXP_MAX)) begin
      o_exp = '1;
      o_ovf = 1'b1;
    end else begin
      // A denormal that rounds up into the hidden bit becomes exponent 1 here.
      o_exp  = w_m[MANT_W] ? w_exp[EXP_W-1:0] : '0;
      o_frac = w_m[MANT_W-1:0];
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-add stage: iterative one-bit-per-cycle normalisation, RNE rounding
// and packing, with valid/ready handshakes and one operation in flight.
module fp_normalize_round
  import fp_normalize_round_pkg::*;
(
  input logic               clk,
  input logic               rst,
  fp_normalize_round_if.slave bus
);

  state_t           r_state;
  state_t           w_next;
  logic             r_sign;
  exp_int_t         r_exp;
  logic [SUM_W-1:0] r_sum;
  logic [31:0]      r_result;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_in_ready;
  logic             w_out_valid;
  exp_int_t         w_in_exp;
  logic [SUM_W-1:0] w_sh_sum;
  exp_int_t         w_sh_exp;
  logic [EXP_W-1:0] w_rexp;
  logic [MANT_W-1:0] w_rfrac;
  logic             w_rovf;

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_in_exp = {2'b00, bus.in_exp};
  assign w_sh_sum = {r_sum[SUM_W-2:0], 1'b0};
  assign w_sh_exp = r_exp - exp_int_t'(1);

  fp_normalize_round_rne u_rne (
    .i_sum  (r_sum[SUM_W-2:0]),
    .i_exp  (r_exp),
    .o_exp  (w_rexp),
    .o_frac (w_rfrac),
    .o_ovf  (w_rovf)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Denormal inputs (exp==1) skip NORM entirely: there is no exponent to spend.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.in_sum == '0)
            w_next = DONE;
          else if (bus.in_sum[CARRY_B] || bus.in_sum[HIDDEN_B] ||
                   w_in_exp == exp_int_t'(1))
            w_next = ROUND;
          else
            w_next = NORM;
        end
      end
      NORM: begin
        if (w_sh_sum[HIDDEN_B] || w_sh_exp == exp_int_t'(1))
          w_next = ROUND;
      end
      ROUND: w_next = DONE;
      DONE: begin
        if (bus.out_ready)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == IDLE) && !rst;
    w_out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_sum    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign <= bus.in_sign;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            if (bus.in_sum == '0) begin
              r_zero   <= 1'b1;
              r_result <= '0;
            end
            // Carry-out: shift right once, folding both dropped-side bits into sticky.
            if (bus.in_sum[CARRY_B]) begin
              r_sum <= {1'b0, bus.in_sum[SUM_W-1:2], bus.in_sum[1] | bus.in_sum[0]};
              r_exp <= w_in_exp + exp_int_t'(1);
            end else begin
              r_sum <= bus.in_sum;
              r_exp <= w_in_exp;
            end
          end
        end
        NORM: begin
          r_sum <= w_sh_sum;
          r_exp <= w_sh_exp;
        end
        ROUND: begin
          r_result <= {r_sign, w_rexp, w_rfrac};
          r_ovf    <= w_rovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_result = r_result;
  assign bus.out_ovf    = r_ovf;
  assign bus.out_zero   = r_zero;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed and randomised checks of fp_normalize_round against an exact
// value-level RNE reference model.
module tb_fp_normalize_round;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fp_normalize_round_if bus ();

  fp_normalize_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Exact value = sum * 2^(exp-153); round once to the float grid.
  task automatic model(input logic sg, input int ex, input logic [27:0] sm,
                       output logic [31:0] res, output logic ovf,
                       output logic zero, output int lat);
    int p, e, ee, qexp, k, be, nsh;
    longint s, q, rem, half;
    res = '0; ovf = 1'b0; zero = 1'b0; lat = 1;
    if (sm == '0) begin
      zero = 1'b1;
      return;
    end
    p = -1;
    for (int i = 0; i < 28; i++) if (sm[i]) p = i;
    e = ex - 153;
    ee = p + e;
    qexp = (ee < -126) ? -149 : ee - 23;
    k = qexp - e;
    s = longint'(sm);
    if (k > 0) begin
      q = s >>> k;
      rem = s - (q <<< k);
      half = 64'sd1 <<< (k - 1);
      if (rem > half || (rem == half && (q & 64'sd1) != 0)) q++;
    end else begin
      q = s <<< (-k);
    end
    if (q >= (64'sd1 <<< 24)) begin
      q = q >>> 1;
      qexp++;
    end
    if (q >= (64'sd1 <<< 23)) begin
      be = qexp + 150;
      if (be >= 255) begin
        res = {sg, 8'hFF, 23'h0};
        ovf = 1'b1;
      end else begin
        res = {sg, 8'(be), 23'(q - (64'sd1 <<< 23))};
      end
    end else begin
      res = {sg, 8'h00, 23'(q)};
    end
    nsh = (p >= 26) ? 0 : (((26 - p) < (ex - 1)) ? (26 - p) : (ex - 1));
    lat = 2 + nsh;
  endtask

  task automatic run(input string tag, input logic sg, input logic [7:0] ex,
                     input logic [27:0] sm, input int hold);
    logic [31:0] eres;
    logic eovf, ezero;
    int elat, n, lat;
    model(sg, int'(ex), sm, eres, eovf, ezero, elat);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_sign  = sg;
    bus.in_exp   = ex;
    bus.in_sum   = sm;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_result"}, bus.out_result, eres);
    chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eovf));
    chk({tag, "_zero"}, 32'(bus.out_zero), 32'(ezero));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_result"}, bus.out_result, eres);
      chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_released"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [27:0] rs, mask;
    int pos;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;

    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.out_result, 32'd0);
    chk("rst_ovf", 32'(bus.out_ovf), 32'd0);
    chk("rst_zero", 32'(bus.out_zero), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    run("one",        1'b0, 8'd127, 28'h4000000, 0);
    run("carry",      1'b0, 8'd127, 28'h8000000, 0);
    run("carry_s",    1'b0, 8'd127, 28'h8000008, 0);
    run("norm23",     1'b0, 8'd127, 28'h0000008, 0);
    run("tie_even",   1'b0, 8'd127, 28'h4000004, 0);
    run("tie_odd",    1'b0, 8'd127, 28'h400000C, 0);
    run("round_carry",1'b0, 8'd127, 28'h7FFFFFC, 0);
    run("overflow",   1'b0, 8'd254, 28'h8000000, 0);
    run("denormal",   1'b0, 8'd1,   28'h0000008, 0);
    run("zero_hold",  1'b1, 8'd127, 28'h0000000, 5);
    run("neg",        1'b1, 8'd130, 28'h5A5A5A5, 2);
    run("denorm_norm",1'b0, 8'd5,   28'h0000100, 0);

    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b0;
    bus.in_exp   = 8'd127;
    bus.in_sum   = 28'h0000008;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid) break;
    end
    chk("midrst_no_output", 32'(bus.out_valid), 32'd0);
    run("after_rst",  1'b0, 8'd127, 28'h4000000, 0);

    for (int i = 0; i < 150; i++) begin
      pos  = $urandom_range(27, 0);
      mask = 28'((64'd1 << (pos + 1)) - 64'd1);
      rs   = 28'($urandom) & mask;
      if (i % 25 == 0) rs = '0;
      run("rand", 1'($urandom), 8'($urandom_range(254, 1)), rs, $urandom_range(3, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
